// File: rtl/display_value_encoder.sv
// display_value_encoder: turns a 24-bit value into six 4-bit digit codes
// for the seven-segment path. Decimal mode runs a 20-step double-dabble
// conversion; hex mode splits nibbles directly. A lamp-test level drives
// the segment AND-mask so that all segments light.
module display_value_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] value,
  input  logic        hex_mode,
  input  logic        lamp_test,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  BCD0,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD3,
  output logic [3:0]  BCD4,
  output logic [3:0]  BCD5,
  output logic [6:0]  turn_on
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [23:0] DEC_MAX   = 24'd999999;
  localparam logic [4:0]  LAST_ITER = 5'd19;

  state_t      state_q, state_d;
  logic [19:0] bin_q, bin_d;
  logic [23:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] dig_q, dig_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [6:0]  ton_q, ton_d;

  logic [23:0] acc_adj;
  logic [43:0] shifted;

  // Double-dabble step: add 3 to every nibble >= 5, then shift {acc, bin} left.
  always_comb begin
    acc_adj = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      else
        acc_adj[4*i +: 4] = acc_q[4*i +: 4];
    end
    shifted = {acc_adj, bin_q} << 1;
  end

  // Next-state and next-output computation for the conversion sequencer.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    ton_d   = lamp_test ? 7'h00 : 7'h7F;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (hex_mode) begin
            dig_d   = value;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else if (value > DEC_MAX) begin
            dig_d   = {6{4'hE}};
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            bin_d   = value[19:0];
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CONVERT;
          end
        end
      end
      CONVERT: begin
        acc_d = shifted[43:20];
        bin_d = shifted[19:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          dig_d   = shifted[43:20];
          ovf_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // busy/done are registered from the next state so they align with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ton_q   <= 7'h7F;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ton_q   <= ton_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign turn_on  = ton_q;
  assign BCD0     = dig_q[3:0];
  assign BCD1     = dig_q[7:4];
  assign BCD2     = dig_q[11:8];
  assign BCD3     = dig_q[15:12];
  assign BCD4     = dig_q[19:16];
  assign BCD5     = dig_q[23:20];

endmodule

// File: tb/tb_display_value_encoder.sv
// Testbench for display_value_encoder: directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model built from division/modulo arithmetic.
module tb_display_value_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [23:0] value = '0;
  logic        hex_mode = 1'b0;
  logic        lamp_test = 1'b0;
  logic        busy, done, overflow;
  logic [3:0]  BCD0, BCD1, BCD2, BCD3, BCD4, BCD5;
  logic [6:0]  turn_on;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  display_value_encoder dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .hex_mode(hex_mode), .lamp_test(lamp_test),
    .busy(busy), .done(done), .overflow(overflow),
    .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
    .BCD4(BCD4), .BCD5(BCD5), .turn_on(turn_on)
  );

  always #5 clk = ~clk;

  wire [23:0] dut_dig = {BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Decimal digits of v by repeated division, packed one digit per nibble.
  function automatic logic [23:0] dec_digits(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Behavioural model: a countdown of remaining cycles rather than a state machine.
  int unsigned m_left = 0;
  logic        m_done = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_ovf  = 1'b0;
  logic [23:0] m_dig  = '0;
  logic [23:0] m_res  = '0;
  logic [6:0]  m_ton  = 7'h7F;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_busy = 1'b0; m_ovf = 1'b0;
      m_dig = '0; m_ton = 7'h7F;
    end else begin
      m_ton = lamp_test ? 7'h00 : 7'h7F;
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_dig = m_res; m_ovf = 1'b0; m_done = 1'b1;
        end
      end else if (start) begin
        if (hex_mode) begin
          m_dig = value; m_ovf = 1'b0; m_done = 1'b1; m_busy = 1'b1;
        end else if (int'(value) > 999999) begin
          m_dig = 24'hEEEEEE; m_ovf = 1'b1; m_done = 1'b1; m_busy = 1'b1;
        end else begin
          m_res = dec_digits(int'(value)); m_left = 20; m_busy = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("digits", 32'(dut_dig), 32'(m_dig));
      chk("turn_on", 32'(turn_on), 32'(m_ton));
    end
  end

  task automatic do_start(input logic [23:0] v, input logic hx);
    @(negedge clk);
    value = v; hex_mode = hx; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges from the one after the accepting edge until done is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_one(input string nm, input logic [23:0] v, input logic hx,
                         input int lat, input logic [23:0] exp_dig, input logic exp_ovf);
    int n;
    do_start(v, hx);
    wait_done(n);
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_digits"}, 32'(dut_dig), 32'(exp_dig));
    chk({nm, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    @(negedge clk);
    chk({nm, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    logic [23:0] saved;
    logic [23:0] rv;

    // Asynchronous reset, checked mid-cycle with no clock edge involved.
    #2 rst = 1'b1;
    #1;
    chk("rst_digits", 32'(dut_dig), 32'h0);
    chk("rst_turn_on", 32'(turn_on), 32'h7F);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    run_one("dec123456", 24'd123456, 1'b0, 20, 24'h123456, 1'b0);
    run_one("dec999999", 24'd999999, 1'b0, 20, 24'h999999, 1'b0);
    run_one("dec0", 24'd0, 1'b0, 20, 24'h000000, 1'b0);
    run_one("dec1000000", 24'h0F4240, 1'b0, 0, 24'hEEEEEE, 1'b1);
    run_one("hexABCDEF", 24'hABCDEF, 1'b1, 0, 24'hABCDEF, 1'b0);

    // Second start during conversion is ignored.
    do_start(24'd123456, 1'b0);
    repeat (4) @(negedge clk);
    value = 24'd42; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("ignore_latency", 32'(n), 32'd15);
    chk("ignore_digits", 32'(dut_dig), 32'h123456);

    // Reset mid-conversion discards the result and produces no done.
    do_start(24'd123456, 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_digits", 32'(dut_dig), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    run_one("after_abort", 24'd654321, 1'b0, 20, 24'h654321, 1'b0);

    // Lamp test: one-edge latency, digits untouched.
    saved = dut_dig;
    lamp_test = 1'b1;
    @(negedge clk);
    chk("lamp_on", 32'(turn_on), 32'h00);
    chk("lamp_digits", 32'(dut_dig), 32'(saved));
    lamp_test = 1'b0;
    @(negedge clk);
    chk("lamp_off", 32'(turn_on), 32'h7F);

    // Randomized traffic, checked by the per-cycle model comparison.
    repeat (3000) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      start = ($urandom % 4) == 0;
      case ($urandom % 4)
        0: rv = 24'($urandom_range(0, 999999));
        1: rv = 24'($urandom_range(1000000, 24'hFFFFFF));
        2: begin
          case ($urandom % 4)
            0: rv = 24'd0;
            1: rv = 24'd999999;
            2: rv = 24'd1000000;
            default: rv = 24'hFFFFFF;
          endcase
        end
        default: rv = 24'($urandom);
      endcase
      value = rv;
      hex_mode = ($urandom % 3) == 0;
      lamp_test = ($urandom % 8) == 0;
      if (($urandom % 150) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (30) @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
